// File: rtl/exec_pkg.sv
// Shared types and constants for the execute-stage multiplier.
package exec_pkg;

  localparam int XLEN     = 64;
  localparam int REG_AW   = 5;
  localparam int ZERO_REG = 0;

  // Operation encoding on op_sel; 2'b11 has no name and decodes as a plain MUL.
  typedef enum logic [1:0] {
    OP_MUL   = 2'b00,
    OP_UMULH = 2'b01,
    OP_SMULH = 2'b10
  } mul_op_e;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    RUN   = 2'b01,
    FIXUP = 2'b10,
    DONE  = 2'b11
  } mul_state_e;

  // True when the op returns the upper half of the double-width product.
  function automatic logic sel_high(input logic [1:0] op);
    return (op == OP_UMULH) || (op == OP_SMULH);
  endfunction

endpackage

// File: rtl/mul_shift_add_core.sv
// Radix-2 shift-add unsigned multiplier: one multiplier bit per clock, LSB
// first, full double-width accumulator. start_i loads operands and clears
// the accumulator; done_o is high during the clock whose edge adds the last
// bit, so product_o is final from the following cycle onwards.
module mul_shift_add_core #(
  parameter int WIDTH = 64
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               clear_i,
  input  logic               start_i,
  input  logic [WIDTH-1:0]   a_i,
  input  logic [WIDTH-1:0]   b_i,
  output logic               done_o,
  output logic [2*WIDTH-1:0] product_o
);

  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  logic [CW-1:0]      count_q, count_d;
  logic               active_q, active_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [2*WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0]   mplier_q, mplier_d;

  // Next-state: load on start, otherwise add/shift once per active cycle.
  always_comb begin
    count_d  = count_q;
    active_d = active_q;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    if (clear_i) begin
      active_d = 1'b0;
    end else if (start_i) begin
      active_d = 1'b1;
      acc_d    = '0;
      count_d  = '0;
      mcand_d  = {{WIDTH{1'b0}}, a_i};
      mplier_d = b_i;
    end else if (active_q) begin
      if (mplier_q[0]) begin
        acc_d = acc_q + mcand_q;
      end
      mcand_d  = mcand_q << 1;
      mplier_d = mplier_q >> 1;
      // The counter parks on its terminal value rather than wrapping.
      if (count_q == LAST) begin
        active_d = 1'b0;
      end else begin
        count_d = count_q + 1'b1;
      end
    end
  end

  // State registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q  <= '0;
      active_q <= 1'b0;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
    end else begin
      count_q  <= count_d;
      active_q <= active_d;
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
    end
  end

  assign done_o    = active_q && (count_q == LAST);
  assign product_o = acc_q;

endmodule

// File: rtl/exec_mul_unit.sv
// Execute-stage iterative multiplier (MUL / UMULH / SMULH) with register-file
// write-back fields. One op in flight.
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both high; valid never depends on ready, and out_* stay stable while
// out_valid is high and out_ready is low.
module exec_mul_unit #(
  parameter int WIDTH  = 64,
  parameter int REG_AW = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [1:0]        op_sel,
  input  logic [WIDTH-1:0]  op_a,
  input  logic [WIDTH-1:0]  op_b,
  input  logic [REG_AW-1:0] in_wa,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WIDTH-1:0]  out_wd,
  output logic [REG_AW-1:0] out_wa,
  output logic              out_we,
  output logic              busy,
  output logic [1:0]        dbg_state
);

  import exec_pkg::*;

  mul_state_e         state_q, state_d;
  logic [1:0]         op_q, op_d;
  logic [REG_AW-1:0]  wa_q, wa_d;
  logic               neg_q, neg_d;
  logic [WIDTH-1:0]   wd_q, wd_d;
  logic [REG_AW-1:0]  owa_q, owa_d;
  logic               we_q, we_d;
  logic               start;
  logic               is_signed;
  logic [WIDTH-1:0]   core_a, core_b;
  logic               core_done;
  logic [2*WIDTH-1:0] product, product_fix;

  // SMULH runs on magnitudes; the most negative value maps to itself, which
  // read as unsigned is exactly its magnitude.
  assign is_signed = (op_sel == OP_SMULH);
  assign core_a = (is_signed && op_a[WIDTH-1]) ? (~op_a + 1'b1) : op_a;
  assign core_b = (is_signed && op_b[WIDTH-1]) ? (~op_b + 1'b1) : op_b;

  mul_shift_add_core #(.WIDTH(WIDTH)) u_core (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear_i   (flush),
    .start_i   (start),
    .a_i       (core_a),
    .b_i       (core_b),
    .done_o    (core_done),
    .product_o (product)
  );

  assign product_fix = neg_q ? (~product + 1'b1) : product;

  // Next-state and write-back field selection; flush overrides everything.
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    wa_d    = wa_q;
    neg_d   = neg_q;
    wd_d    = wd_q;
    owa_d   = owa_q;
    we_d    = we_q;
    start   = 1'b0;
    if (flush) begin
      state_d = IDLE;
      we_d    = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            start   = 1'b1;
            op_d    = op_sel;
            wa_d    = in_wa;
            neg_d   = is_signed && (op_a[WIDTH-1] ^ op_b[WIDTH-1]);
            state_d = RUN;
          end
        end
        RUN: begin
          if (core_done) begin
            state_d = FIXUP;
          end
        end
        FIXUP: begin
          wd_d    = sel_high(op_q) ? product_fix[2*WIDTH-1:WIDTH] : product_fix[WIDTH-1:0];
          owa_d   = wa_q;
          we_d    = (wa_q != REG_AW'(ZERO_REG));
          state_d = DONE;
        end
        DONE: begin
          if (out_ready) begin
            we_d    = 1'b0;
            state_d = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      op_q    <= '0;
      wa_q    <= '0;
      neg_q   <= 1'b0;
      wd_q    <= '0;
      owa_q   <= '0;
      we_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      wa_q    <= wa_d;
      neg_q   <= neg_d;
      wd_q    <= wd_d;
      owa_q   <= owa_d;
      we_q    <= we_d;
    end
  end

  assign in_ready  = (state_q == IDLE) && !flush;
  assign out_valid = (state_q == DONE);
  assign out_wd    = wd_q;
  assign out_wa    = owa_q;
  assign out_we    = we_q;
  assign busy      = (state_q != IDLE);
  assign dbg_state = state_q;

endmodule

// File: tb/tb_exec_mul_unit.sv
// Bench for exec_mul_unit: directed and random ops, backpressure, zero
// register, flush and reset aborts, back-to-back issue.
module tb_exec_mul_unit;

  localparam int W  = 64;
  localparam int AW = 5;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          flush = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [1:0]    op_sel = 2'b00;
  logic [W-1:0]  op_a = '0;
  logic [W-1:0]  op_b = '0;
  logic [AW-1:0] in_wa = '0;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [W-1:0]  out_wd;
  logic [AW-1:0] out_wa;
  logic          out_we;
  logic          busy;
  logic [1:0]    dbg_state;

  int n_checks = 0;
  int n_errors = 0;

  logic [W-1:0]  exp_q[$];
  logic [AW-1:0] exp_wa_q[$];
  logic          exp_we_q[$];

  exec_mul_unit #(.WIDTH(W), .REG_AW(AW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op_sel    (op_sel),
    .op_a      (op_a),
    .op_b      (op_b),
    .in_wa     (in_wa),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_wd    (out_wd),
    .out_wa    (out_wa),
    .out_we    (out_we),
    .busy      (busy),
    .dbg_state (dbg_state)
  );

  // Clock
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%016h expected 0x%016h", tag, got, exp);
    end
  endtask

  // Reference: plain wide arithmetic.
  function automatic logic [W-1:0] model(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    logic [2*W-1:0] p;
    if (op == 2'b10) p = $signed({{W{a[W-1]}}, a}) * $signed({{W{b[W-1]}}, b});
    else             p = {{W{1'b0}}, a} * {{W{1'b0}}, b};
    return (op == 2'b01 || op == 2'b10) ? p[2*W-1:W] : p[W-1:0];
  endfunction

  // Scoreboard: compare every output handshake against the queue head.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_out", 1, 0);
      end else begin
        check("out_wd", out_wd, exp_q.pop_front());
        check("out_wa", W'(out_wa), W'(exp_wa_q.pop_front()));
        check("out_we", W'(out_we), W'(exp_we_q.pop_front()));
      end
    end
  end

  // Drive one op from just after a posedge; returns 1 time unit after the accept edge.
  task automatic send(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                      input logic [AW-1:0] wa, input logic [W-1:0] exp, input bit push);
    int g;
    in_valid = 1'b1; op_sel = op; op_a = a; op_b = b; in_wa = wa;
    g = 0;
    @(negedge clk);
    while (!in_ready && g < 300) begin
      @(negedge clk);
      g++;
    end
    if (!in_ready) check("accept_timeout", 0, 1);
    if (push) begin
      exp_q.push_back(exp);
      exp_wa_q.push_back(wa);
      exp_we_q.push_back(wa != '0);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  // Wait for out_valid; the acceptance cycle counts as cycle 1.
  task automatic wait_out(input string tag);
    int cyc;
    cyc = 1;
    @(negedge clk);
    while (!out_valid && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
    check(tag, W'(cyc), W'(66));
    if (out_ready) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic run_op(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [AW-1:0] wa, input logic [W-1:0] exp);
    send(op, a, b, wa, exp, 1'b1);
    wait_out("latency");
  endtask

  task automatic watch_no_out(input string tag);
    logic seen;
    seen = 1'b0;
    repeat (80) begin
      @(negedge clk);
      if (out_valid) seen = 1'b1;
    end
    check(tag, W'(seen), 0);
  endtask

  initial begin
    logic [W-1:0]  a, b, wd0;
    logic [AW-1:0] wa0;
    logic [1:0]    op;
    int g;

    // Reset
    #12;
    check("rst_in_ready", W'(in_ready), 1);
    check("rst_out_valid", W'(out_valid), 0);
    check("rst_busy", W'(busy), 0);
    check("rst_out_wd", out_wd, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Directed cases
    run_op(2'b00, 64'd3, 64'd5, 5'd7, 64'd15);
    run_op(2'b01, '1, '1, 5'd1, 64'hFFFF_FFFF_FFFF_FFFE);
    run_op(2'b00, '1, '1, 5'd2, 64'd1);
    run_op(2'b10, 64'hFFFF_FFFF_FFFF_FFFD, 64'd5, 5'd3, 64'hFFFF_FFFF_FFFF_FFFF);
    run_op(2'b00, 64'hFFFF_FFFF_FFFF_FFFD, 64'd5, 5'd4, 64'hFFFF_FFFF_FFFF_FFF1);
    run_op(2'b10, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 5'd5, 64'h4000_0000_0000_0000);
    run_op(2'b11, 64'd1000, 64'd1000, 5'd6, 64'd1000000);

    // Random ops against the wide-arithmetic model
    for (int i = 0; i < 6; i++) begin
      op = 2'($urandom_range(0, 3));
      a  = {$urandom, $urandom};
      b  = {$urandom, $urandom};
      run_op(op, a, b, 5'($urandom_range(1, 31)), model(op, a, b));
    end

    // Backpressure with destination register 0
    out_ready = 1'b0;
    send(2'b00, 64'd7, 64'd9, 5'd0, 64'd63, 1'b1);
    wait_out("bp_latency");
    wd0 = out_wd;
    wa0 = out_wa;
    in_valid = 1'b1; op_sel = 2'b00; op_a = 64'd1; op_b = 64'd1; in_wa = 5'd3;
    repeat (10) begin
      @(negedge clk);
      check("bp_wd_stable", out_wd, wd0);
      check("bp_wa_stable", W'(out_wa), W'(wa0));
      check("bp_in_ready", W'(in_ready), 0);
      check("bp_out_valid", W'(out_valid), 1);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("bp_in_ready_after", W'(in_ready), 1);
    check("bp_out_valid_after", W'(out_valid), 0);
    check("bp_queue_drained", W'(exp_q.size()), 0);
    @(posedge clk); #1;

    // Flush at RUN cycle 20
    send(2'b01, 64'hDEAD_BEEF_0000_1111, 64'h1234_5678_9ABC_DEF0, 5'd9, '0, 1'b0);
    repeat (19) @(posedge clk);
    #1;
    check("flush_busy_before", W'(busy), 1);
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    @(negedge clk);
    check("flush_in_ready", W'(in_ready), 1);
    check("flush_busy", W'(busy), 0);
    check("flush_state", W'(dbg_state), 0);
    watch_no_out("flush_no_out");

    // Reset pulse mid-RUN
    @(posedge clk); #1;
    send(2'b00, 64'd11, 64'd13, 5'd10, '0, 1'b0);
    repeat (30) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("arst_in_ready", W'(in_ready), 1);
    check("arst_out_valid", W'(out_valid), 0);
    check("arst_out_we", W'(out_we), 0);
    check("arst_out_wd", out_wd, 0);
    check("arst_out_wa", W'(out_wa), 0);
    check("arst_busy", W'(busy), 0);
    @(negedge clk);
    rst_n = 1'b1;
    watch_no_out("arst_no_out");

    // Back-to-back: second op held valid while the first runs
    @(posedge clk); #1;
    send(2'b00, 64'd21, 64'd2, 5'd12, 64'd42, 1'b1);
    in_valid = 1'b1; op_sel = 2'b01; op_a = '1; op_b = 64'd4; in_wa = 5'd13;
    exp_q.push_back(64'd3); exp_wa_q.push_back(5'd13); exp_we_q.push_back(1'b1);
    g = 0;
    @(negedge clk);
    while (!out_valid && g < 100) begin
      if (in_ready) check("b2b_early_accept", 1, 0);
      @(negedge clk);
      g++;
    end
    check("b2b_first_done", W'(out_valid), 1);
    @(posedge clk);
    @(negedge clk);
    check("b2b_accept", W'(in_ready), 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    wait_out("b2b_latency");

    check("queue_empty", W'(exp_q.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
